// File: rtl/triggerrec_pkg.sv
// Shared widths, event-word layout and the loss-marker builder for the
// trigger recorder event path.
package triggerrec_pkg;

    localparam int         EVT_W     = 64;
    localparam int         PAYLOAD_W = 60;
    localparam logic [3:0] MARKER_ID = 4'hF;

    typedef struct packed {
        logic [3:0]           id;
        logic [PAYLOAD_W-1:0] payload;
    } evt_word_t;

    // Marker: reserved id, source id, loss count, low 28 bits zero.
    function automatic logic [EVT_W-1:0] mk_marker(input logic [3:0]  id,
                                                   input logic [27:0] loss);
        return {MARKER_ID, id, loss, 28'h0};
    endfunction

endpackage

// File: rtl/triggerrec_rr_pick.sv
// Combinational round-robin picker: the first requester at or after rr wins.
module triggerrec_rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [3:0]         rr,
    output logic [NUM_SRC-1:0] gnt_onehot,
    output logic [3:0]         gnt_idx,
    output logic               gnt_any
);
    logic [2*NUM_SRC-1:0] rot;
    int                   off;
    int                   idx;

    always_comb begin
        // Rotate so bit 0 is the source at rr, then take the lowest set bit.
        rot = {req, req} >> rr;
        off = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (rot[k]) off = k;
        gnt_any = |req;
        idx     = int'(rr) + off;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        gnt_idx    = 4'(idx);
        gnt_onehot = '0;
        for (int j = 0; j < NUM_SRC; j++)
            gnt_onehot[j] = gnt_any && (idx == j);
    end

endmodule

// File: rtl/triggerrec_evt_arbiter.sv
// Per-source event holding slots with round-robin write access to the event
// FIFO, saturating drop counters and in-band loss markers.
module triggerrec_evt_arbiter
    import triggerrec_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int LOSS_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_pulse,
    input  logic [NUM_SRC*PAYLOAD_W-1:0] src_data,
    input  logic                         fifo_afull,
    output logic                         fifo_shift,
    output logic [EVT_W-1:0]             fifo_data,
    output logic                         busy,
    input  logic [3:0]                   drop_sel,
    output logic [LOSS_W-1:0]            drop_cnt
);
    logic [NUM_SRC-1:0]                slot_v;
    logic [NUM_SRC-1:0][PAYLOAD_W-1:0] slot_d;
    logic [NUM_SRC-1:0][LOSS_W-1:0]    loss;
    logic [3:0]                        rr;

    logic [NUM_SRC-1:0]   req, gnt, take, drop;
    logic [3:0]           gnt_idx, rr_nxt;
    logic                 gnt_any;
    logic                 win_v;
    logic [PAYLOAD_W-1:0] win_d;
    logic [LOSS_W-1:0]    win_loss, sel_loss;
    evt_word_t            evt_w;

    // Masking requests with afull holds the pointer as well as the grant.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SRC; i++)
            req[i] = !fifo_afull && (slot_v[i] || loss[i] != '0);
    end

    triggerrec_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req        (req),
        .rr         (rr),
        .gnt_onehot (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_comb begin
        win_v    = 1'b0;
        win_d    = '0;
        win_loss = '0;
        sel_loss = '0;
        take     = '0;
        drop     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                win_v    = slot_v[i];
                win_d    = slot_d[i];
                win_loss = loss[i];
            end
            if (drop_sel == 4'(i)) sel_loss = loss[i];
            // A slot being drained this cycle can take the new pulse.
            take[i] = enable && src_pulse[i] && (!slot_v[i] || gnt[i]);
            drop[i] = enable && src_pulse[i] && slot_v[i] && !gnt[i];
        end
        rr_nxt = (int'(gnt_idx) == NUM_SRC - 1) ? 4'd0 : gnt_idx + 4'd1;
        evt_w  = '{id: gnt_idx, payload: win_d};
    end

    assign busy = (|slot_v) || (|loss);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            slot_v     <= '0;
            slot_d     <= '0;
            loss       <= '0;
            rr         <= '0;
            fifo_shift <= 1'b0;
            fifo_data  <= '0;
            drop_cnt   <= '0;
        end else begin
            fifo_shift <= gnt_any;
            drop_cnt   <= sel_loss;
            if (gnt_any) begin
                rr        <= rr_nxt;
                fifo_data <= win_v ? evt_w : mk_marker(gnt_idx, 28'(win_loss));
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (take[i]) begin
                    slot_v[i] <= 1'b1;
                    slot_d[i] <= src_data[i*PAYLOAD_W +: PAYLOAD_W];
                end else if (gnt[i]) begin
                    slot_v[i] <= 1'b0;
                end
                if (gnt[i] && !slot_v[i])
                    loss[i] <= drop[i] ? LOSS_W'(1) : '0;
                else if (drop[i] && loss[i] != '1)
                    loss[i] <= loss[i] + LOSS_W'(1);
            end
        end
    end

endmodule
